mul_seq_ctrl: RTL and testbench

//  Iterative 32x32 multiply sequencer for the RV32 M-extension ops MUL, MULH, MULHSU and MULHU.

---
 rtl/mul_pkg.sv | 21 ++
 rtl/wallace_8x8.sv | 45 ++++
 rtl/mul_seq_ctrl.sv | 132 +++++++++++++
 tb/tb_mul_seq_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the iterative RV32 M-extension multiplier.
// Op encodings, FSM states and step bounds.
package mul_pkg;

    localparam int XLEN  = 32;
    localparam int NBYTE = XLEN / 8;

    localparam logic [1:0] MUL_OP_MUL    = 2'b00;
    localparam logic [1:0] MUL_OP_MULH   = 2'b01;
    localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
    localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

    localparam logic [3:0] STEP_LAST = 4'(NBYTE * NBYTE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        FIX  = 2'd2
    } state_e;

endpackage

// File: rtl/wallace_8x8.sv
// 8x8 unsigned carry-save multiplier tree.
// Low 5 bits resolved; upper bits left as two vectors to add.
module wallace_8x8 (
    input  logic [7:0]  a_i,
    input  logic [7:0]  b_i,
    output logic [15:5] x_o,
    output logic [15:5] y_o,
    output logic [4:0]  z_o
);

    // 3:2 compressor over 16-bit rows, {sum, carry<<1}
    function automatic logic [31:0] csa(
        input logic [15:0] p,
        input logic [15:0] q,
        input logic [15:0] r
    );
        logic [15:0] s;
        logic [15:0] m;
        s = p ^ q ^ r;
        m = (p & q) | (p & r) | (q & r);
        return {s, m[14:0], 1'b0};
    endfunction

    logic [15:0] pp [8];
    logic [31:0] l1a, l1b, l2a, l2b, l3, l4;
    logic [5:0]  low;

    // Partial-product rows and four compressor levels down to two rows
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            pp[k] = b_i[k] ? (16'(a_i) << k) : 16'd0;
        end
        l1a = csa(pp[0], pp[1], pp[2]);
        l1b = csa(pp[3], pp[4], pp[5]);
        l2a = csa(l1a[31:16], l1a[15:0], l1b[31:16]);
        l2b = csa(l1b[15:0], pp[6], pp[7]);
        l3  = csa(l2a[31:16], l2a[15:0], l2b[31:16]);
        l4  = csa(l3[31:16], l3[15:0], l2b[15:0]);
        low = {1'b0, l4[20:16]} + {1'b0, l4[4:0]};
        z_o = low[4:0];
        x_o = l4[31:21];
        y_o = l4[15:5] + {10'd0, low[5]};
    end

endmodule

// File: rtl/mul_seq_ctrl.sv
// Iterative 32x32 multiply sequencer for MUL/MULH/MULHSU/MULHU.
// One 8x8 tree, 16 byte steps into a 64-bit accumulator.
module mul_seq_ctrl
    import mul_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    input  logic            kill_i,
    output logic            ready_o,
    output logic            busy_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o
);

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [63:0]     acc_q, acc_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic            neg_q, neg_d;
    logic [1:0]      op_q, op_d;
    logic [XLEN-1:0] res_q, res_d;
    logic            valid_q, valid_d;

    logic [7:0]  a_byte, b_byte;
    logic [15:5] tx, ty;
    logic [4:0]  tz;
    logic [15:0] pp16;
    logic [2:0]  ij;
    logic [63:0] pp_sh;
    logic [63:0] prod;
    logic        sa, sb;

    assign a_byte = a_q[8*cnt_q[1:0] +: 8];
    assign b_byte = b_q[8*cnt_q[3:2] +: 8];

    wallace_8x8 u_tree (
        .a_i (a_byte),
        .b_i (b_byte),
        .x_o (tx),
        .y_o (ty),
        .z_o (tz)
    );

    // Resolve the tree output and place it at byte offset i+j
    always_comb begin
        pp16  = {tx + ty, tz};
        ij    = {1'b0, cnt_q[1:0]} + {1'b0, cnt_q[3:2]};
        pp_sh = {48'd0, pp16} << {ij, 3'b000};
        prod  = neg_q ? -acc_q : acc_q;
        sa    = ((op_i == MUL_OP_MULH) || (op_i == MUL_OP_MULHSU)) && op_a_i[31];
        sb    = (op_i == MUL_OP_MULH) && op_b_i[31];
    end

    // FSM and datapath next-state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        a_d     = a_q;
        b_d     = b_q;
        neg_d   = neg_q;
        op_d    = op_q;
        res_d   = res_q;
        valid_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i && !kill_i) begin
                    op_d    = op_i;
                    a_d     = sa ? -op_a_i : op_a_i;
                    b_d     = sb ? -op_b_i : op_b_i;
                    neg_d   = sa ^ sb;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = MULT;
                end
            end
            MULT: begin
                if (kill_i) begin
                    state_d = IDLE;
                end else begin
                    acc_d = acc_q + pp_sh;
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == STEP_LAST) state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
                if (!kill_i) begin
                    res_d   = (op_q == MUL_OP_MUL) ? prod[31:0] : prod[63:32];
                    valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            neg_q   <= 1'b0;
            op_q    <= '0;
            res_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            neg_q   <= neg_d;
            op_q    <= op_d;
            res_q   <= res_d;
            valid_q <= valid_d;
        end
    end

    assign ready_o  = (state_q == IDLE);
    assign busy_o   = (state_q != IDLE);
    assign valid_o  = valid_q;
    assign result_o = res_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Scoreboard bench for mul_seq_ctrl: directed corners,
// kill/reset/back-to-back cases and a random sweep.
module tb_mul_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        kill;
    logic        ready_o;
    logic        busy_o;
    logic        valid_o;
    logic [31:0] result_o;

    typedef struct {
        logic [31:0] res;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] last_res = 32'd0;

    mul_seq_ctrl dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .start_i  (start),
        .op_i     (op),
        .op_a_i   (a),
        .op_b_i   (b),
        .kill_i   (kill),
        .ready_o  (ready_o),
        .busy_o   (busy_o),
        .valid_o  (valid_o),
        .result_o (result_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] o,
                                          input logic [31:0] x,
                                          input logic [31:0] y);
        logic [63:0] ex, ey, p;
        ex = (o == 2'b01 || o == 2'b10) ? {{32{x[31]}}, x} : {32'd0, x};
        ey = (o == 2'b01) ? {{32{y[31]}}, y} : {32'd0, y};
        p  = ex * ey;
        return (o == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    // Result monitor: pop expectation on each valid pulse
    always @(negedge clk) begin
        if (!rst && valid_o) begin
            if (q.size() == 0) begin
                check("spurious_valid", 64'(valid_o), 64'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("result", 64'(result_o), 64'(e.res));
                check("latency", 64'(cyc - e.cyc), 64'd18);
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!ready_o && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!ready_o) check("ready_timeout", 64'(ready_o), 64'd1);
    endtask

    // Start is raised before ready, so it is held through busy
    task automatic do_op(input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] exp);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        wait_ready();
        q.push_back('{exp, cyc});
        last_res = exp;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 2'($urandom);
        a     = $urandom;
        b     = $urandom;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (q.size() != 0) check("drain_timeout", 64'(q.size()), 64'd0);
        #1;
    endtask

    function automatic logic [31:0] pick();
        unique case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        rst   = 1'b1;
        start = 1'b0;
        kill  = 1'b0;
        op    = 2'd0;
        a     = 32'd0;
        b     = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 64'(ready_o), 64'd1);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_valid", 64'(valid_o), 64'd0);
        check("rst_result", 64'(result_o), 64'd0);
        rst = 1'b0;

        do_op(2'b00, 32'd7, 32'd6, 32'h0000_002A);
        do_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
        do_op(2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        do_op(2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF);
        do_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op(2'b10, 32'd2, 32'h8000_0000, 32'h0000_0001);
        wait_drain();

        // Kill in MULT at cycle 5, new op the next cycle
        op = 2'b00; a = 32'd9; b = 32'd9; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("kill_busy", 64'(busy_o), 64'd1);
        repeat (4) @(posedge clk);
        #1;
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        check("kill_ready", 64'(ready_o), 64'd1);
        check("kill_result_held", 64'(result_o), 64'(last_res));
        do_op(2'b00, 32'd3, 32'd5, 32'h0000_000F);
        wait_drain();

        // Kill in IDLE beats start
        op = 2'b00; a = 32'd4; b = 32'd4; start = 1'b1; kill = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        kill  = 1'b0;
        check("kill_idle_ready", 64'(ready_o), 64'd1);
        check("kill_idle_busy", 64'(busy_o), 64'd0);
        repeat (20) @(posedge clk);
        #1;

        // Reset mid-op at cycle 9
        op = 2'b00; a = 32'd11; b = 32'd13; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_ready", 64'(ready_o), 64'd1);
        check("mid_rst_busy", 64'(busy_o), 64'd0);
        check("mid_rst_valid", 64'(valid_o), 64'd0);
        check("mid_rst_result", 64'(result_o), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;

        // Random back-to-back sweep
        for (int i = 0; i < 2000; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = pick();
            rb = pick();
            do_op(ro, ra, rb, model(ro, ra, rb));
        end
        wait_drain();
        repeat (25) @(posedge clk);
        check("queue_empty", 64'(q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
